// File: rtl/spi_loader_pkg.sv
// Shared types and constants for the SPI flash boot loader.
package spi_loader_pkg;

  typedef enum logic [2:0] {
    START,
    CMD,
    READ,
    WR0,
    WR1,
    WR2,
    DONE
  } state_t;

  localparam logic [7:0] CMD_READ = 8'h03;

  // Number of clk cycles the SRAM write strobe is held low (WR0 plus WR1).
  localparam int WE_PULSE_CLKS = 2;

  // Shift length select for spi_shift_master.
  localparam logic LEN_8  = 1'b0;
  localparam logic LEN_32 = 1'b1;

endpackage

// File: rtl/spi_shift_master.sv
// SPI mode-0 shifter: SCLK divider plus an 8- or 32-bit MSB-first shift.
// `done` is high in the cycle before the final falling SCLK edge, so the
// caller can act on the same edge that returns SCLK low.
module spi_shift_master
  import spi_loader_pkg::*;
#(
  parameter int SCLK_DIV = 2
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        go,
  input  logic        len,
  input  logic        hold,
  input  logic [31:0] tx_word,
  input  logic        miso,
  output logic        busy,
  output logic        done,
  output logic        sclk,
  output logic        mosi,
  output logic [7:0]  rx_byte
);

  localparam int DIV_W = $clog2(SCLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(SCLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       bit_cnt;
  logic [31:0]      tx_sr;
  logic             tick;

  assign tick = busy && !hold && (div_cnt == '0);
  assign done = tick && sclk && (bit_cnt == 5'd0);

  // Divider down-counter, SCLK toggle, MOSI shift on fall, MISO sample on rise.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      busy    <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_byte <= '0;
    end else if (go) begin
      busy    <= 1'b1;
      sclk    <= 1'b0;
      div_cnt <= DIV_LOAD;
      bit_cnt <= (len == LEN_32) ? 5'd31 : 5'd7;
      tx_sr   <= tx_word;
      mosi    <= tx_word[31];
    end else if (tick) begin
      div_cnt <= DIV_LOAD;
      sclk    <= !sclk;
      if (!sclk) begin
        rx_byte <= {rx_byte[6:0], miso};
      end else begin
        tx_sr <= {tx_sr[30:0], 1'b0};
        mosi  <= tx_sr[30];
        if (bit_cnt == 5'd0) busy <= 1'b0;
        else bit_cnt <= bit_cnt - 5'd1;
      end
    end else if (busy && !hold) begin
      div_cnt <= div_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/spi_flash_loader.sv
// Boot loader: reads IMAGE_BYTES from SPI flash (READ 0x03) and writes them
// into SRAM, then hands the SRAM pins over to the CPU.
//
// state | meaning
// START | first clk after reset: assert CS, launch 32-bit command/address
// CMD   | shifting {0x03, FLASH_ADDR}
// READ  | shifting in one data byte
// WR0   | WE low, first cycle
// WR1   | WE low, remaining cycles of the pulse
// WR2   | WE high, advance address / byte count
// DONE  | CS released, cpm_* passed straight through to ext_*
module spi_flash_loader
  import spi_loader_pkg::*;
#(
  parameter int          IMAGE_BYTES = 65536,
  parameter logic [23:0] FLASH_ADDR  = 24'h000000,
  parameter logic [17:0] RAM_BASE    = 18'h00000,
  parameter int          SCLK_DIV    = 2
) (
  input  logic        clk,
  input  logic        n_reset,
  output logic        booting,
  output logic        flashCS_b,
  output logic        flashSCLK,
  output logic        flashMOSI,
  input  logic        flashMISO,
  input  logic        cpm_RAMCS_b,
  input  logic        cpm_RAMOE_b,
  input  logic        cpm_RAMWE_b,
  input  logic [17:0] cpm_RAMA,
  input  logic [7:0]  cpm_RAMDin,
  output logic        ext_RAMCS_b,
  output logic        ext_RAMOE_b,
  output logic        ext_RAMWE_b,
  output logic [17:0] ext_RAMA,
  output logic [7:0]  ext_RAMDin
);

  localparam int CNT_W = $clog2(IMAGE_BYTES + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMAGE_BYTES - 1);
  localparam logic [1:0] WE_TMR_LOAD = 2'(WE_PULSE_CLKS - 2);

  state_t           state;
  logic             cs_b_r;
  logic             we_b_r;
  logic [17:0]      ram_a;
  logic [7:0]       ram_d;
  logic [CNT_W-1:0] count;
  logic [1:0]       we_tmr;
  logic             last_byte;

  logic        sh_go;
  logic        sh_len;
  logic        sh_hold;
  logic [31:0] sh_tx;
  logic        sh_busy;
  logic        sh_done;
  logic [7:0]  sh_rx;

  assign last_byte = (count == LAST_IDX);

  // Shifter launch: command at START, first byte one idle clk after the
  // command, following bytes straight out of WR2 so the stream never re-issues.
  always_comb begin
    sh_go  = 1'b0;
    sh_len = LEN_8;
    sh_tx  = '0;
    case (state)
      START: begin
        sh_go  = 1'b1;
        sh_len = LEN_32;
        sh_tx  = {CMD_READ, FLASH_ADDR};
      end
      READ:    sh_go = !sh_busy;
      WR2:     sh_go = !last_byte;
      default: sh_go = 1'b0;
    endcase
  end

  assign sh_hold = (state == WR0) || (state == WR1) || (state == WR2) || (state == DONE);

  spi_shift_master #(
    .SCLK_DIV(SCLK_DIV)
  ) u_shift (
    .clk    (clk),
    .n_reset(n_reset),
    .go     (sh_go),
    .len    (sh_len),
    .hold   (sh_hold),
    .tx_word(sh_tx),
    .miso   (flashMISO),
    .busy   (sh_busy),
    .done   (sh_done),
    .sclk   (flashSCLK),
    .mosi   (flashMOSI),
    .rx_byte(sh_rx)
  );

  // Load sequencer with registered CS, WE, address, data and booting flag.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state   <= START;
      booting <= 1'b1;
      cs_b_r  <= 1'b1;
      we_b_r  <= 1'b1;
      ram_a   <= RAM_BASE;
      ram_d   <= '0;
      count   <= '0;
      we_tmr  <= '0;
    end else begin
      case (state)
        START: begin
          cs_b_r <= 1'b0;
          state  <= CMD;
        end
        CMD: if (sh_done) state <= READ;
        READ: if (sh_done) begin
          ram_d  <= sh_rx;
          we_b_r <= 1'b0;
          we_tmr <= WE_TMR_LOAD;
          state  <= WR0;
        end
        WR0: state <= WR1;
        WR1: begin
          if (we_tmr == 2'd0) begin
            we_b_r <= 1'b1;
            state  <= WR2;
          end else begin
            we_tmr <= we_tmr - 2'd1;
          end
        end
        WR2: begin
          count <= count + 1'b1;
          if (last_byte) begin
            booting <= 1'b0;
            cs_b_r  <= 1'b1;
            state   <= DONE;
          end else begin
            ram_a <= ram_a + 18'd1;
            state <= READ;
          end
        end
        DONE: state <= DONE;
        default: state <= START;
      endcase
    end
  end

  assign flashCS_b   = cs_b_r;
  assign ext_RAMCS_b = booting ? 1'b0   : cpm_RAMCS_b;
  assign ext_RAMOE_b = booting ? 1'b1   : cpm_RAMOE_b;
  assign ext_RAMWE_b = booting ? we_b_r : cpm_RAMWE_b;
  assign ext_RAMA    = booting ? ram_a  : cpm_RAMA;
  assign ext_RAMDin  = booting ? ram_d  : cpm_RAMDin;

endmodule

// File: tb/tb_spi_flash_loader.sv
// Bench for spi_flash_loader: behavioural SPI flash, SRAM write monitor,
// load-time count, mid-load reset, pass-through table, address wrap.
module tb_spi_flash_loader;

  localparam int          DIV       = 2;
  localparam int          N_A       = 4;
  localparam int          N_B       = 2;
  localparam logic [23:0] FADDR     = 24'h020000;
  localparam logic [17:0] BASE_A    = 18'h00000;
  localparam logic [17:0] BASE_B    = 18'h3FFFF;
  localparam logic [31:0] EXP_CMD   = {8'h03, FADDR};
  localparam int          LOAD_CLKS = 64 * DIV + N_A * (16 * DIV + 3) + 2;

  logic clk;
  logic n_reset;
  logic cpm_RAMCS_b, cpm_RAMOE_b, cpm_RAMWE_b;
  logic [17:0] cpm_RAMA;
  logic [7:0]  cpm_RAMDin;

  logic booting_a, flashCS_b_a, flashSCLK_a, flashMOSI_a, flashMISO_a;
  logic ext_RAMCS_b_a, ext_RAMOE_b_a, ext_RAMWE_b_a;
  logic [17:0] ext_RAMA_a;
  logic [7:0]  ext_RAMDin_a;

  logic booting_b, flashCS_b_b, flashSCLK_b, flashMOSI_b, flashMISO_b;
  logic ext_RAMCS_b_b, ext_RAMOE_b_b, ext_RAMWE_b_b;
  logic [17:0] ext_RAMA_b;
  logic [7:0]  ext_RAMDin_b;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] img_a [N_A];
  logic [7:0] img_b [N_B];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  spi_flash_loader #(
    .IMAGE_BYTES(N_A), .FLASH_ADDR(FADDR), .RAM_BASE(BASE_A), .SCLK_DIV(DIV)
  ) dut_a (
    .clk(clk), .n_reset(n_reset), .booting(booting_a),
    .flashCS_b(flashCS_b_a), .flashSCLK(flashSCLK_a), .flashMOSI(flashMOSI_a),
    .flashMISO(flashMISO_a),
    .cpm_RAMCS_b(cpm_RAMCS_b), .cpm_RAMOE_b(cpm_RAMOE_b), .cpm_RAMWE_b(cpm_RAMWE_b),
    .cpm_RAMA(cpm_RAMA), .cpm_RAMDin(cpm_RAMDin),
    .ext_RAMCS_b(ext_RAMCS_b_a), .ext_RAMOE_b(ext_RAMOE_b_a), .ext_RAMWE_b(ext_RAMWE_b_a),
    .ext_RAMA(ext_RAMA_a), .ext_RAMDin(ext_RAMDin_a)
  );

  spi_flash_loader #(
    .IMAGE_BYTES(N_B), .FLASH_ADDR(FADDR), .RAM_BASE(BASE_B), .SCLK_DIV(DIV)
  ) dut_b (
    .clk(clk), .n_reset(n_reset), .booting(booting_b),
    .flashCS_b(flashCS_b_b), .flashSCLK(flashSCLK_b), .flashMOSI(flashMOSI_b),
    .flashMISO(flashMISO_b),
    .cpm_RAMCS_b(cpm_RAMCS_b), .cpm_RAMOE_b(cpm_RAMOE_b), .cpm_RAMWE_b(cpm_RAMWE_b),
    .cpm_RAMA(cpm_RAMA), .cpm_RAMDin(cpm_RAMDin),
    .ext_RAMCS_b(ext_RAMCS_b_b), .ext_RAMOE_b(ext_RAMOE_b_b), .ext_RAMWE_b(ext_RAMWE_b_b),
    .ext_RAMA(ext_RAMA_b), .ext_RAMDin(ext_RAMDin_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Flash model A: counts rising SCLK edges while selected; first 32 are the
  // command, then image bits are presented MSB first.
  int nb_a, k_a;
  logic [31:0] cmd_sr_a, cmd_seen_a;
  logic [7:0]  byte_a;
  always @(posedge flashSCLK_a or posedge flashCS_b_a or negedge n_reset) begin
    if (!n_reset) begin
      nb_a = 0; cmd_sr_a = '0; cmd_seen_a = '0;
    end else if (flashCS_b_a) begin
      nb_a = 0;
    end else begin
      if (nb_a < 32) cmd_sr_a = {cmd_sr_a[30:0], flashMOSI_a};
      nb_a++;
      if (nb_a == 32) cmd_seen_a = cmd_sr_a;
    end
  end
  always_comb begin
    k_a = nb_a - 32;
    byte_a = 8'h00;
    flashMISO_a = 1'b0;
    if (nb_a >= 32 && k_a < 8 * N_A) begin
      byte_a = img_a[k_a / 8];
      flashMISO_a = byte_a[3'(7 - (k_a % 8))];
    end
  end

  // Flash model B (wrap instance).
  int nb_b, k_b;
  logic [31:0] cmd_sr_b, cmd_seen_b;
  logic [7:0]  byte_b;
  always @(posedge flashSCLK_b or posedge flashCS_b_b or negedge n_reset) begin
    if (!n_reset) begin
      nb_b = 0; cmd_sr_b = '0; cmd_seen_b = '0;
    end else if (flashCS_b_b) begin
      nb_b = 0;
    end else begin
      if (nb_b < 32) cmd_sr_b = {cmd_sr_b[30:0], flashMOSI_b};
      nb_b++;
      if (nb_b == 32) cmd_seen_b = cmd_sr_b;
    end
  end
  always_comb begin
    k_b = nb_b - 32;
    byte_b = 8'h00;
    flashMISO_b = 1'b0;
    if (nb_b >= 32 && k_b < 8 * N_B) begin
      byte_b = img_b[k_b / 8];
      flashMISO_b = byte_b[3'(7 - (k_b % 8))];
    end
  end

  // SRAM monitor A: checks each boot-time WE pulse and logs the write.
  logic [17:0] wr_addr_a [$];
  logic [7:0]  wr_data_a [$];
  int low_a;
  logic [17:0] addr0_a;
  logic [7:0]  data0_a;
  always @(negedge clk) begin
    if (!n_reset) begin
      low_a = 0;
    end else if (booting_a && !ext_RAMWE_b_a) begin
      if (low_a == 0) begin
        addr0_a = ext_RAMA_a;
        data0_a = ext_RAMDin_a;
      end else begin
        chk("we_addr_stable", 32'(ext_RAMA_a), 32'(addr0_a));
        chk("we_data_stable", 32'(ext_RAMDin_a), 32'(data0_a));
      end
      chk("we_sclk_low", 32'(flashSCLK_a), 32'd0);
      chk("we_oe_high", 32'(ext_RAMOE_b_a), 32'd1);
      low_a++;
    end else if (low_a != 0) begin
      chk("we_pulse_len", 32'(low_a), 32'd2);
      wr_addr_a.push_back(addr0_a);
      wr_data_a.push_back(data0_a);
      low_a = 0;
    end
  end

  // SRAM monitor B: logs the write on the first low cycle of each pulse.
  logic [17:0] wr_addr_b [$];
  logic [7:0]  wr_data_b [$];
  logic prev_we_b;
  always @(negedge clk) begin
    if (!n_reset) begin
      prev_we_b = 1'b1;
    end else begin
      if (booting_b && !ext_RAMWE_b_b && prev_we_b) begin
        wr_addr_b.push_back(ext_RAMA_b);
        wr_data_b.push_back(ext_RAMDin_b);
      end
      prev_we_b = ext_RAMWE_b_b | !booting_b;
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_booting"}, 32'(booting_a), 32'd1);
    chk({tag, "_cs_b"}, 32'(flashCS_b_a), 32'd1);
    chk({tag, "_sclk"}, 32'(flashSCLK_a), 32'd0);
    chk({tag, "_mosi"}, 32'(flashMOSI_a), 32'd0);
    chk({tag, "_we_b"}, 32'(ext_RAMWE_b_a), 32'd1);
    chk({tag, "_oe_b"}, 32'(ext_RAMOE_b_a), 32'd1);
    chk({tag, "_ramcs_b"}, 32'(ext_RAMCS_b_a), 32'd0);
    chk({tag, "_rama"}, 32'(ext_RAMA_a), 32'(BASE_A));
    chk({tag, "_din"}, 32'(ext_RAMDin_a), 32'd0);
  endtask

  // Reset, release on a falling clk edge, then count rising edges until
  // booting is seen low.
  task automatic run_load(output int cyc);
    n_reset = 1'b0;
    wr_addr_a.delete(); wr_data_a.delete();
    wr_addr_b.delete(); wr_data_b.delete();
    @(negedge clk);
    n_reset = 1'b1;
    cyc = 0;
    while (booting_a && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic check_writes_a(input string tag);
    chk({tag, "_wr_count"}, 32'(wr_addr_a.size()), 32'(N_A));
    for (int i = 0; i < N_A && i < wr_addr_a.size(); i++) begin
      chk({tag, "_wr_addr"}, 32'(wr_addr_a[i]), 32'(18'(BASE_A + 18'(i))));
      chk({tag, "_wr_data"}, 32'(wr_data_a[i]), 32'(img_a[i]));
    end
  endtask

  typedef struct {
    logic        cs, oe, we;
    logic [17:0] a;
    logic [7:0]  d;
    logic        e_cs, e_oe, e_we;
    logic [17:0] e_a;
    logic [7:0]  e_d;
  } pt_vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pt_vec_t tbl [5];
    int cyc, cnt;
    logic [31:0] r;
    logic [28:0] exp_pt;

    tbl[0] = '{1'b0, 1'b1, 1'b0, 18'h01234, 8'h5A, 1'b0, 1'b1, 1'b0, 18'h01234, 8'h5A};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 18'h3FFFF, 8'hFF, 1'b1, 1'b1, 1'b1, 18'h3FFFF, 8'hFF};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 18'h00000, 8'h00, 1'b0, 1'b0, 1'b1, 18'h00000, 8'h00};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 18'h2AAAA, 8'hA5, 1'b0, 1'b1, 1'b0, 18'h2AAAA, 8'hA5};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 18'h15555, 8'h3C, 1'b1, 1'b0, 1'b0, 18'h15555, 8'h3C};

    img_a = '{8'hA5, 8'h3C, 8'h00, 8'hFF};
    img_b = '{8'h96, 8'h0F};

    // CPU-side noise while booting: must not reach the SRAM pins.
    cpm_RAMCS_b = 1'b1; cpm_RAMOE_b = 1'b0; cpm_RAMWE_b = 1'b0;
    cpm_RAMA = 18'h2AAAA; cpm_RAMDin = 8'hC3;

    n_reset = 1'b1;
    #12 n_reset = 1'b0;
    #1 check_reset_values("reset");

    // Fixed image load.
    run_load(cyc);
    chk("load_cycles", 32'(cyc), 32'(LOAD_CLKS));
    chk("cmd_bits", cmd_seen_a, EXP_CMD);
    check_writes_a("fixed");
    chk("done_cs_b", 32'(flashCS_b_a), 32'd1);

    // Wrap instance finished earlier.
    chk("wrap_booting", 32'(booting_b), 32'd0);
    chk("wrap_cmd_bits", cmd_seen_b, EXP_CMD);
    chk("wrap_wr_count", 32'(wr_addr_b.size()), 32'(N_B));
    for (int i = 0; i < N_B && i < wr_addr_b.size(); i++) begin
      chk("wrap_wr_addr", 32'(wr_addr_b[i]), 32'(18'(BASE_B + 18'(i))));
      chk("wrap_wr_data", 32'(wr_data_b[i]), 32'(img_b[i]));
    end

    // Pass-through table after DONE.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cpm_RAMCS_b = tbl[i].cs; cpm_RAMOE_b = tbl[i].oe; cpm_RAMWE_b = tbl[i].we;
      cpm_RAMA = tbl[i].a; cpm_RAMDin = tbl[i].d;
      #1;
      chk("pt_cs_b", 32'(ext_RAMCS_b_a), 32'(tbl[i].e_cs));
      chk("pt_oe_b", 32'(ext_RAMOE_b_a), 32'(tbl[i].e_oe));
      chk("pt_we_b", 32'(ext_RAMWE_b_a), 32'(tbl[i].e_we));
      chk("pt_rama", 32'(ext_RAMA_a), 32'(tbl[i].e_a));
      chk("pt_din", 32'(ext_RAMDin_a), 32'(tbl[i].e_d));
      chk("pt_wrap_inst", 32'({ext_RAMCS_b_b, ext_RAMWE_b_b, ext_RAMA_b, ext_RAMDin_b}),
          32'({tbl[i].e_cs, tbl[i].e_we, tbl[i].e_a, tbl[i].e_d}));
      chk("pt_flash_cs_b", 32'(flashCS_b_a), 32'd1);
      chk("pt_booting", 32'(booting_a), 32'd0);
    end

    // Random pass-through: after the load the SRAM pins are the CPU pins.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      r = $urandom;
      cpm_RAMCS_b = r[0]; cpm_RAMOE_b = r[1]; cpm_RAMWE_b = r[2];
      cpm_RAMA = r[20:3]; cpm_RAMDin = r[28:21];
      exp_pt = {r[0], r[1], r[2], r[20:3], r[28:21]};
      #1;
      chk("pt_rand", 32'({ext_RAMCS_b_a, ext_RAMOE_b_a, ext_RAMWE_b_a, ext_RAMA_a, ext_RAMDin_a}),
          32'(exp_pt));
      @(posedge clk);
      #1;
      chk("pt_rand_cs_b", 32'(flashCS_b_a), 32'd1);
    end

    // Reset during byte 2, then full restart.
    cpm_RAMCS_b = 1'b1; cpm_RAMOE_b = 1'b0; cpm_RAMWE_b = 1'b0;
    cpm_RAMA = 18'h15555; cpm_RAMDin = 8'h99;
    n_reset = 1'b0;
    wr_addr_a.delete(); wr_data_a.delete();
    @(negedge clk);
    n_reset = 1'b1;
    cnt = 0;
    while (wr_addr_a.size() < 1 && cnt < 1000) begin
      @(posedge clk);
      cnt++;
    end
    chk("mid_first_write", 32'(wr_addr_a.size()), 32'd1);
    repeat (20) @(posedge clk);
    #1;
    chk("mid_pre_rama", 32'(ext_RAMA_a), 32'(BASE_A + 18'd1));
    chk("mid_pre_cs_b", 32'(flashCS_b_a), 32'd0);
    #2 n_reset = 1'b0;
    #1 check_reset_values("mid_reset");
    run_load(cyc);
    chk("restart_cycles", 32'(cyc), 32'(LOAD_CLKS));
    chk("restart_cmd_bits", cmd_seen_a, EXP_CMD);
    check_writes_a("restart");

    // Random image.
    n_reset = 1'b0;
    for (int i = 0; i < N_A; i++) img_a[i] = 8'($urandom);
    run_load(cyc);
    chk("rand_cycles", 32'(cyc), 32'(LOAD_CLKS));
    chk("rand_cmd_bits", cmd_seen_a, EXP_CMD);
    check_writes_a("rand");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
